// File: rtl/spi_master.sv
// spi_master: single-byte, LSB-first SPI initiator for the team's SPI slave block.
// Every output is registered; each frame carries exactly 8 internal_clk falling edges.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode_in,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       internal_clk,
  output logic       enable,
  output logic       MODE,
  output logic       input_data,
  input  logic       output_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] div_cnt_r;
  logic [7:0] div_cnt_next_s;
  logic [2:0] bit_cnt_r;
  logic [2:0] bit_cnt_next_s;
  logic [7:0] tx_shift_r;
  logic [7:0] rx_shift_r;
  logic [7:0] rx_shift_next_s;
  logic       phase_end_s;
  logic       frame_active_s;
  logic       enter_high_s;

  assign phase_end_s    = (div_cnt_r == DIV_LAST);
  assign frame_active_s = (state_next_s == SETUP) || (state_next_s == HIGH) || (state_next_s == LOW);
  assign enter_high_s   = (state_next_s == HIGH) && (state_r != HIGH);

  // Next-state, divider, bit counter and receive-capture logic
  always_comb begin
    state_next_s    = state_r;
    div_cnt_next_s  = div_cnt_r;
    bit_cnt_next_s  = bit_cnt_r;
    rx_shift_next_s = rx_shift_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s   = SETUP;
          div_cnt_next_s = 8'd0;
          bit_cnt_next_s = 3'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP, HIGH: begin
        if (phase_end_s) begin
          state_next_s   = (state_r == SETUP) ? HIGH : LOW;
          div_cnt_next_s = 8'd0;
        end else begin
          div_cnt_next_s = div_cnt_r + 8'd1;
        end
      end
      LOW: begin
        if (phase_end_s) begin
          // Sample a full half-period after the slave drove on the falling edge
          if (!MODE) begin
            rx_shift_next_s[bit_cnt_r] = output_data;
          end else begin
            rx_shift_next_s = rx_shift_r;
          end
          div_cnt_next_s = 8'd0;
          if (bit_cnt_r == 3'd7) begin
            state_next_s = DONE;
          end else begin
            state_next_s   = HIGH;
            bit_cnt_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          div_cnt_next_s = div_cnt_r + 8'd1;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s   = IDLE;
        div_cnt_next_s = 8'd0;
        bit_cnt_next_s = 3'd0;
      end
    endcase
  end

  // State, counters and shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      bit_cnt_r  <= 3'd0;
      tx_shift_r <= 8'd0;
      rx_shift_r <= 8'd0;
    end else begin
      state_r    <= state_next_s;
      div_cnt_r  <= div_cnt_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      rx_shift_r <= rx_shift_next_s;
      if ((state_r == IDLE) && start) begin
        tx_shift_r <= tx_data;
      end
    end
  end

  // Registered interface outputs, decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      internal_clk <= 1'b0;
      enable       <= 1'b1;
      MODE         <= 1'b0;
      input_data   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_data      <= 8'h00;
    end else begin
      internal_clk <= (state_next_s == HIGH);
      enable       <= !frame_active_s;
      busy         <= (state_next_s != IDLE);
      done         <= (state_next_s == DONE);
      // Data line only moves on acceptance or HIGH entry, never near the falling edge
      if ((state_r == IDLE) && start) begin
        MODE       <= mode_in;
        input_data <= mode_in & tx_data[0];
      end else if (enter_high_s) begin
        input_data <= MODE & tx_shift_r[bit_cnt_next_s];
      end else if ((state_next_s == IDLE) || (state_next_s == DONE)) begin
        input_data <= 1'b0;
      end
      if ((state_r == LOW) && (state_next_s == DONE) && !MODE) begin
        rx_data <= rx_shift_next_s;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV=4 and 1), each paired with a
// behavioural model of the team's SPI slave (3-bit counter that never resets itself).
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, mode4 = 1'b0, start1 = 1'b0, mode1 = 1'b0;
  logic [7:0] tx4 = 8'h00, tx1 = 8'h00;
  logic [7:0] rx4, rx1;
  logic       busy4, done4, ic4, en4, md4, di4, busy1, done1, ic1, en1, md1, di1;
  logic       sl4_out, sl1_out;

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode_in(mode4), .tx_data(tx4),
    .rx_data(rx4), .busy(busy4), .done(done4), .internal_clk(ic4), .enable(en4),
    .MODE(md4), .input_data(di4), .output_data(sl4_out)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode_in(mode1), .tx_data(tx1),
    .rx_data(rx1), .busy(busy1), .done(done1), .internal_clk(ic1), .enable(en1),
    .MODE(md1), .input_data(di1), .output_data(sl1_out)
  );

  // Slave models: sample or drive on each selected falling edge of internal_clk
  logic       sl_init = 1'b0;
  logic [7:0] sl4_store, sl1_store, cap4, cap1;
  logic [2:0] sl4_cnt, sl1_cnt;
  int         falls4 = 0, falls1 = 0;

  always @(negedge ic4 or posedge sl_init) begin
    if (sl_init) sl4_cnt <= 3'd0;
    else if (!en4) begin
      if (md4) sl4_store[sl4_cnt] <= di4;
      else sl4_out <= sl4_store[sl4_cnt];
      cap4    <= {di4, cap4[7:1]};
      sl4_cnt <= sl4_cnt + 3'd1;
      falls4  <= falls4 + 1;
    end
  end

  always @(negedge ic1 or posedge sl_init) begin
    if (sl_init) sl1_cnt <= 3'd0;
    else if (!en1) begin
      if (md1) sl1_store[sl1_cnt] <= di1;
      else sl1_out <= sl1_store[sl1_cnt];
      cap1    <= {di1, cap1[7:1]};
      sl1_cnt <= sl1_cnt + 3'd1;
      falls1  <= falls1 + 1;
    end
  end

  // Continuous monitors sampled mid-cycle
  int done_cnt4 = 0, done_cnt1 = 0, sel_viol = 0, rd_di_hi = 0;
  always @(negedge clk) begin
    if (done4 === 1'b1) done_cnt4++;
    if (done1 === 1'b1) done_cnt1++;
    if ((busy4 === 1'b0) && (en4 !== 1'b1)) sel_viol++;
    if ((busy1 === 1'b0) && (en1 !== 1'b1)) sel_viol++;
    if ((busy4 === 1'b1) && (md4 === 1'b0) && (di4 !== 1'b0)) rd_di_hi++;
    if ((busy1 === 1'b1) && (md1 === 1'b0) && (di1 !== 1'b0)) rd_di_hi++;
  end

  int tests_run = 0, tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit which, input logic s, input logic m, input logic [7:0] d);
    if (which) begin start1 = s; mode1 = m; tx1 = d; end
    else begin start4 = s; mode4 = m; tx4 = d; end
  endtask

  // Issue one frame; lat = rising edges from acceptance until done is seen (-1 on timeout)
  task automatic frame(input bit which, input logic m, input logic [7:0] d, input bit junk,
                       input bit now, output int lat, output logic md_mid);
    lat = -1;
    md_mid = 1'bx;
    if (!now) @(negedge clk);
    drive(which, 1'b1, m, d);
    @(posedge clk);
    #1;
    drive(which, 1'b0, ~m, ~d);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      drive(which, junk && (i == 4 || i == 39), ~m, 8'hEE);
      if (i == 8) md_mid = which ? md1 : md4;
      if ((which ? done1 : done4) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic after_frame(input bit which, input string tag);
    @(posedge clk);
    #1;
    if (which) check(tag, {29'd0, busy1, done1, en1}, 32'h1);
    else check(tag, {29'd0, busy4, done4, en4}, 32'h1);
  endtask

  int   lat, f0, d0, r0;
  logic mm;

  initial begin
    #3 rst = 1'b1;
    #1;
    check("reset4_ctrl", {26'd0, en4, ic4, md4, di4, busy4, done4}, 32'h20);
    check("reset4_rx", {24'd0, rx4}, 32'h00);
    check("reset1_ctrl", {26'd0, en1, ic1, md1, di1, busy1, done1}, 32'h20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sl_init = 1'b1;
    #1 sl_init = 1'b0;

    // WRITE 8'hA5 at CLK_DIV=4
    f0 = falls4;
    frame(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, lat, mm);
    check("w_a5_latency", lat, 68);
    check("w_a5_mode_mid", {31'd0, mm}, 32'h1);
    check("w_a5_slave_store", {24'd0, sl4_store}, 32'hA5);
    check("w_a5_line_bits", {24'd0, cap4}, 32'hA5);
    check("w_a5_falls", falls4 - f0, 8);
    check("w_a5_rx_unchanged", {24'd0, rx4}, 32'h00);
    after_frame(1'b0, "w_a5_busy_drop");

    // Preload 8'h3C, then READ it back
    frame(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, lat, mm);
    after_frame(1'b0, "w_3c_busy_drop");
    f0 = falls4;
    r0 = rd_di_hi;
    frame(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, lat, mm);
    check("r_3c_rx", {24'd0, rx4}, 32'h3C);
    check("r_3c_latency", lat, 68);
    check("r_3c_mode_mid", {31'd0, mm}, 32'h0);
    check("r_3c_falls", falls4 - f0, 8);
    check("r_3c_di_low", rd_di_hi - r0, 0);
    after_frame(1'b0, "r_3c_busy_drop");

    // Back-to-back WRITE 8'h01 then READ on first IDLE cycle, with stray starts
    d0 = done_cnt4;
    frame(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, lat, mm);
    check("b2b_w_latency", lat, 68);
    @(posedge clk);
    #1;
    frame(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, lat, mm);
    check("b2b_r_latency", lat, 68);
    check("b2b_r_rx", {24'd0, rx4}, 32'h01);
    after_frame(1'b0, "b2b_busy_drop");
    repeat (60) @(posedge clk);
    #1;
    check("b2b_done_pulses", done_cnt4 - d0, 2);

    // CLK_DIV=1: WRITE 8'hFF then READ
    f0 = falls1;
    frame(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, lat, mm);
    check("d1_w_latency", lat, 17);
    check("d1_w_falls", falls1 - f0, 8);
    after_frame(1'b1, "d1_w_busy_drop");
    frame(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, lat, mm);
    check("d1_r_latency", lat, 17);
    check("d1_r_rx", {24'd0, rx1}, 32'hFF);
    after_frame(1'b1, "d1_r_busy_drop");

    // Reset during bit 3 of a WRITE
    d0 = done_cnt4;
    f0 = falls4;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'hC3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < 200 && (falls4 - f0) < 3; i++) @(posedge clk);
    check("abort_reached_bit3", falls4 - f0, 3);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ctrl", {28'd0, en4, ic4, busy4, done4}, 32'h8);
    check("abort_rx", {24'd0, rx4}, 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sl_init = 1'b1;
    #1 sl_init = 1'b0;
    check("abort_no_done", done_cnt4 - d0, 0);
    frame(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, lat, mm);
    check("abort_next_latency", lat, 68);
    after_frame(1'b0, "abort_next_busy_drop");
    frame(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, lat, mm);
    check("abort_readback", {24'd0, rx4}, 32'h5A);
    after_frame(1'b0, "abort_read_busy_drop");

    check("select_when_idle", sel_viol, 0);
    check("read_di_low_all", rd_di_hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI initiator that drives the team's SPI slave block.
- Generates the serial clock (internal_clk), the active-low select (enable) and the direction select (MODE). In WRITE mode it shifts out a byte; in READ mode it shifts in the slave's storage byte.
- Sits between a local request/response handshake on the system clock and the slave's four-wire interface.
- Both directions run LSB first, 8 bits per frame.

Parameters:
- CLK_DIV, 4, number of clk cycles per half-period of internal_clk; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode_in  input  1  1 = WRITE (master to slave), 0 = READ (slave to master); latched on start.
- tx_data  input  8  byte to send; latched on start.
- rx_data  output  8  last byte received in READ mode.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at end of frame.
- internal_clk  output  1  serial clock to the slave; idles low.
- enable  output  1  slave select, active low; idles high.
- MODE  output  1  direction to the slave; holds the latched mode_in.
- input_data  output  1  serial data to the slave's input_data.
- output_data  input  1  serial data from the slave's output_data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: internal_clk=0, enable=1, MODE=0, input_data=0, busy=0, done=0, rx_data=8'h00.
  - State goes to IDLE; divider count, bit count and shift registers clear.
- Slave contract:
  - The slave samples input_data, or drives output_data, on each falling edge of internal_clk while enable=0.
  - The slave keeps its own 3-bit counter that never resets. Every frame must therefore contain exactly 8 falling edges, or the slave desynchronises.
  - Reset mid-frame aborts with fewer than 8 edges. After such an abort the system must also re-initialise the slave.
- FSM states: IDLE, SETUP, HIGH, LOW, DONE.
  - div_cnt counts 0..CLK_DIV-1 in SETUP, HIGH and LOW. The phase ends at the edge where div_cnt = CLK_DIV-1.
- IDLE: enable=1, internal_clk=0, busy=0.
  - When start=1, latch tx_data into the shift register and mode_in into MODE. Set bit_cnt=0, busy=1, and go to SETUP.
- SETUP: lasts CLK_DIV cycles with enable=0 and internal_clk=0.
  - WRITE: input_data = tx bit 0.
  - READ: input_data = 0.
  - Next state: HIGH.
- HIGH: lasts CLK_DIV cycles with internal_clk=1.
  - input_data = tx bit[bit_cnt] in WRITE, 0 in READ.
  - It updates only on entry to HIGH, a half-period before the falling edge.
  - Next state: LOW, and internal_clk falls, which is the slave's sample/drive edge.
- LOW: lasts CLK_DIV cycles with internal_clk=0.
  - At the final cycle of LOW in READ mode, capture output_data into rx shift bit[bit_cnt].
  - If bit_cnt=7, go to DONE; otherwise increment bit_cnt and go to HIGH.
- DONE: lasts 1 cycle with enable=1, internal_clk=0, done=1, busy=1.
  - READ: rx_data is loaded from the rx shift register and is visible in the same cycle as done.
  - WRITE: rx_data is unchanged.
  - Next state: IDLE.
- Timing:
  - done is high in the cycle after the 17*CLK_DIV-th rising clk edge following the accepting edge.
  - Equivalently, it appears 68 edges after acceptance for CLK_DIV=4.
  - busy falls one cycle later.
  - Each frame produces exactly 8 internal_clk pulses.
- start while busy=1, including the DONE cycle, is ignored; there is no queueing.
- Back-to-back frames always have at least 2 cycles with enable=1 between them (DONE plus IDLE).
- tx_data and mode_in changes after acceptance have no effect on the current frame.
- MODE stays stable from acceptance until the next accepted start; it does not toggle inside a frame.

Test Plan:
- WRITE 8'hA5, CLK_DIV=4, paired with the slave block:
  - Slave storage_slave = 8'hA5 after the frame.
  - input_data at the 8 falling edges = 1,0,1,0,0,1,0,1.
  - done is high 68 edges after start.
- READ with the slave preloaded to 8'h3C:
  - rx_data = 8'h3C in the done cycle.
  - input_data stays 0 throughout.
  - MODE = 0 during the frame.
- Edge count and select:
  - Count internal_clk falling edges while enable=0 for each frame -> exactly 8.
  - enable=1 at all times when busy=0.
- Back-to-back traffic:
  - WRITE 8'h01, then READ issued on the first IDLE cycle -> rx_data = 8'h01.
  - start pulses during busy (at cycles 5 and 40) are ignored -> exactly 2 done pulses.
- CLK_DIV=1:
  - WRITE 8'hFF then READ -> rx_data = 8'hFF.
  - done is high 17 edges after start.
- Reset mid-frame:
  - Assert rst at bit 3 of a WRITE -> outputs go to reset values immediately (enable=1, internal_clk=0, busy=0), with no done pulse.
  - After reset the next start is accepted normally.
